// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES-128/192/256 decryption, one round per clock; `define INV_CIPHER_ITER_DROP_FLAG_EN adds o_drop
module inv_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [32*NK-1:0] i_key,
  input  logic [127:0]     i_data,
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
  output logic             o_drop,
`endif
  output logic             o_busy,
  output logic             o_valid,
  output logic [127:0]     o_data
);
  localparam int RW = $clog2(NR + 1);
  localparam int NW = 4 * (NR + 1);
  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} fsm_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction
  function automatic logic [128*(NR+1)-1:0] expand(input logic [32*NK-1:0] k);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0] rc;
    logic [128*(NR+1)-1:0] e;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = k[32*NK-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) t = sub_word(t);
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NW; i++) e[128*(NR+1)-1-32*i -: 32] = w[i];
    return e;
  endfunction
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                               gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
  fsm_e fsm_q, fsm_d;
  logic [32*NK-1:0] key_q, key_d;
  logic [127:0] state_q, state_d, data_q, data_d, sr;
  logic [RW-1:0] round_q, round_d;
  logic valid_q, valid_d;
  logic [128*(NR+1)-1:0] ek;
  logic [127:0] rk [NR+1];
  assign ek = expand(key_q);
  for (genvar g = 0; g <= NR; g++) assign rk[g] = ek[128*(NR+1)-1-128*g -: 128];
  assign sr = inv_shift_sub(state_q);
  always_comb begin
    fsm_d = fsm_q;
    key_d = key_q;
    state_d = state_q;
    round_d = round_q;
    data_d = data_q;
    valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        key_d = i_start ? i_key : key_q;
        state_d = i_start ? i_data : state_q;
        fsm_d = i_start ? INIT : IDLE;
      end
      INIT: begin
        state_d = state_q ^ rk[NR];
        round_d = RW'(NR - 1);
        fsm_d = ROUND;
      end
      ROUND: begin
        state_d = inv_mix(sr ^ rk[round_q]);
        fsm_d = round_q == RW'(1) ? FINAL : ROUND;
        round_d = round_q == RW'(1) ? round_q : round_q - RW'(1);
      end
      default: begin
        data_d = sr ^ rk[0];
        valid_d = 1'b1;
        fsm_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      fsm_q <= IDLE;
      key_q <= '0;
      state_q <= '0;
      round_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      key_q <= key_d;
      state_q <= state_d;
      round_q <= round_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  assign o_busy = fsm_q != IDLE;
  assign o_valid = valid_q;
  assign o_data = data_q;
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
  logic drop_q, drop_d;
  assign drop_d = i_start & o_busy;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) drop_q <= 1'b0;
    else drop_q <= drop_d;
  assign o_drop = drop_q;
`endif
endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: scoreboard bench for AES-128/192/256 inverse cipher against a forward-AES reference model
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] start, busy, valid;
  logic [127:0] din [3];
  logic [127:0] dout [3];
  logic [255:0] key [3];
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
  logic [2:0] drop;
`endif
  inv_cipher_iter #(.NK(4), .NR(10)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_key(key[0][255:128]), .i_data(din[0]),
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
    .o_drop(drop[0]),
`endif
    .o_busy(busy[0]), .o_valid(valid[0]), .o_data(dout[0]));
  inv_cipher_iter #(.NK(6), .NR(12)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_key(key[1][255:64]), .i_data(din[1]),
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
    .o_drop(drop[1]),
`endif
    .o_busy(busy[1]), .o_valid(valid[1]), .o_data(dout[1]));
  inv_cipher_iter #(.NK(8), .NR(14)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_key(key[2]), .i_data(din[2]),
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
    .o_drop(drop[2]),
`endif
    .o_busy(busy[2]), .o_valid(valid[2]), .o_data(dout[2]));
  typedef struct {
    logic [127:0] d;
    int t;
  } exp_t;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  logic [127:0] last [3];
  logic [7:0] sb [256];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int nr_of(input int u);
    return 10 + 2 * u;
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] y;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = y;
    end
  endtask
  function automatic logic [127:0] enc(input logic [255:0] k, input logic [127:0] pt, input int nk, input int nr);
    logic [31:0] w [60];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] x;
    logic [7:0] rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      x = w[i-1];
      if (i % nk == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) x = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
      w[i] = w[i-nk] ^ x;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[4*((b/4 + b%4) % 4) + b%4]];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask
  task automatic push(input int u, input exp_t e);
    if (u == 0) q0.push_back(e);
    else if (u == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    int n;
    if (rst_n)
      for (int u = 0; u < 3; u++)
        if (valid[u]) begin
          n = u == 0 ? q0.size() : u == 1 ? q1.size() : q2.size();
          if (n == 0) chk($sformatf("u%0d unexpected o_valid", u), 128'(valid[u]), 128'(0));
          else begin
            if (u == 0) e = q0.pop_front();
            else if (u == 1) e = q1.pop_front();
            else e = q2.pop_front();
            chk($sformatf("u%0d o_data", u), dout[u], e.d);
            chk($sformatf("u%0d o_valid cycle", u), 128'(cyc), 128'(e.t));
            chk($sformatf("u%0d o_busy at o_valid", u), 128'(busy[u]), 128'(0));
            last[u] = e.d;
          end
        end
  end
  task automatic issue(input int u, input logic [255:0] k, input logic [127:0] ct, input logic [127:0] pt,
                       input bit hold, output int acc);
    exp_t e;
    int n;
    n = 0;
    while (busy[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy[u]) chk($sformatf("u%0d busy timeout", u), 128'(busy[u]), 128'(0));
    key[u] = k;
    din[u] = ct;
    start[u] = 1'b1;
    acc = cyc + 1;
    e.d = pt;
    e.t = cyc + nr_of(u) + 2;
    push(u, e);
    @(negedge clk);
    if (!hold) start[u] = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q0.size() + q1.size() + q2.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drain", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
  endtask
  localparam logic [255:0] K1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc;
    logic [255:0] k;
    logic [127:0] pt;
    exp_t e;
    start = '0;
    for (int u = 0; u < 3; u++) begin
      key[u] = '0;
      din[u] = '0;
    end
    build_sbox();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d reset o_busy", u), 128'(busy[u]), 128'(0));
      chk($sformatf("u%0d reset o_valid", u), 128'(valid[u]), 128'(0));
      chk($sformatf("u%0d reset o_data", u), dout[u], 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, K1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, 1'b1, acc);
    key[0] = K2;
    din[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    e.d = PT2;
    e.t = acc + 12 + 11;
    push(0, e);
    repeat (10) @(negedge clk);
    chk("u0 b2b busy before FINAL", 128'(busy[0]), 128'(1));
    @(negedge clk);
    chk("u0 b2b idle after FINAL", 128'(busy[0]), 128'(0));
    @(negedge clk);
    chk("u0 b2b second acceptance", 128'(busy[0]), 128'(1));
    start[0] = 1'b0;
    issue(1, K192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT0, 1'b0, acc);
    issue(2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PT0, 1'b0, acc);
    drain();
    repeat (5) @(negedge clk);
    chk("u0 o_data holds", dout[0], last[0]);
    issue(0, K1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, 1'b0, acc);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    key[0] = K2;
    din[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    @(negedge clk);
    start[0] = 1'b0;
    chk("u0 busy during ignored start", 128'(busy[0]), 128'(1));
`ifdef INV_CIPHER_ITER_DROP_FLAG_EN
    chk("u0 o_drop pulse", 128'(drop[0]), 128'(1));
    @(negedge clk);
    chk("u0 o_drop one cycle", 128'(drop[0]), 128'(0));
`endif
    drain();
    repeat (20) @(negedge clk);
    issue(0, K1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("u0 mid reset o_busy", 128'(busy[0]), 128'(0));
    chk("u0 mid reset o_valid", 128'(valid[0]), 128'(0));
    chk("u0 mid reset o_data", dout[0], 128'(0));
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(0, K1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT0, 1'b0, acc);
    drain();
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 6; i++) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (u == 0) k[127:0] = '0;
        if (u == 1) k[63:0] = '0;
        pt = {$urandom, $urandom, $urandom, $urandom};
        issue(u, k, enc(k, pt, 4 + 2 * u, nr_of(u)), pt, 1'($urandom_range(0, 1)), acc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      start[u] = 1'b0;
    end
    drain();
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
